// File: rtl/pixel_memory_if.sv
// Pixel store bus: renderer write port plus two display read ports.
// Semantics: no valid/ready; the write is taken on any rising edge where we=1, and each
// read address is sampled every rising edge with its data registered one cycle later.
interface pixel_memory_if #(
    parameter int AW = 16,
    parameter int DW = 3
);
    logic          we;
    logic [AW-1:0] waddr;
    logic [AW-1:0] raddr;
    logic [AW-1:0] raddr2;
    logic [DW-1:0] din;
    logic [DW-1:0] dout;
    logic [DW-1:0] dout2;

    modport master (
        output we, waddr, raddr, raddr2, din,
        input  dout, dout2
    );

    modport slave (
        input  we, waddr, raddr, raddr2, din,
        output dout, dout2
    );
endinterface

// File: rtl/pixel_memory.sv
// Frame-buffer pixel store: one write port, two synchronous read ports, and a
// reset-triggered sweep that writes colour 0 to every location.
module pixel_memory #(
    parameter int PX_WIDTH  = 160,
    parameter int PX_HEIGHT = 120,
    parameter int DEPTH     = PX_WIDTH * PX_HEIGHT,
    parameter int AW        = 16,
    parameter int DW        = 3
) (
    input  logic          clk,
    input  logic          rst,
    pixel_memory_if.slave bus,
    output logic          dbg_clearing,
    output logic [AW-1:0] dbg_clr_addr
);
    localparam int            IW      = $clog2(DEPTH);
    localparam logic [AW-1:0] DEPTH_A = AW'(DEPTH);
    localparam logic [AW-1:0] LAST_A  = AW'(DEPTH - 1);

    typedef enum logic {ST_IDLE, ST_CLEAR} state_e;

    state_e        state;
    logic [AW-1:0] clr_addr;

    logic [DW-1:0] mem [DEPTH];

    logic          mem_we;
    logic [IW-1:0] mem_idx;
    logic [DW-1:0] mem_wdata;

    // The sweep owns the single write port; renderer writes are dropped while it runs.
    always_comb begin
        mem_we    = 1'b0;
        mem_idx   = bus.waddr[IW-1:0];
        mem_wdata = bus.din;
        if (rst) begin
            mem_we = 1'b0;
        end else if (state == ST_CLEAR) begin
            mem_we    = 1'b1;
            mem_idx   = clr_addr[IW-1:0];
            mem_wdata = '0;
        end else if (bus.we && (bus.waddr < DEPTH_A)) begin
            mem_we = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_idx] <= mem_wdata;
        end
    end

    // Reads sample the array before this edge's write lands, giving read-first collisions.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_CLEAR;
            clr_addr  <= '0;
            bus.dout  <= '0;
            bus.dout2 <= '0;
        end else begin
            bus.dout  <= ((state == ST_IDLE) && (bus.raddr < DEPTH_A))
                         ? mem[bus.raddr[IW-1:0]] : '0;
            bus.dout2 <= ((state == ST_IDLE) && (bus.raddr2 < DEPTH_A))
                         ? mem[bus.raddr2[IW-1:0]] : '0;
            if (state == ST_CLEAR) begin
                if (clr_addr == LAST_A) begin
                    state    <= ST_IDLE;
                    clr_addr <= '0;
                end else begin
                    clr_addr <= clr_addr + 1'b1;
                end
            end
        end
    end

    assign dbg_clearing = (state == ST_CLEAR);
    assign dbg_clr_addr = clr_addr;
endmodule

// File: tb/tb_pixel_memory.sv
// Directed and randomized bench for pixel_memory against an array-level reference model.
module tb_pixel_memory;
    localparam int DEPTH = 19200;
    localparam int AW    = 16;
    localparam int DW    = 3;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    pixel_memory_if #(.AW(AW), .DW(DW)) bus ();
    logic          dbg_clearing;
    logic [AW-1:0] dbg_clr_addr;

    pixel_memory dut (
        .clk          (clk),
        .rst          (rst),
        .bus          (bus),
        .dbg_clearing (dbg_clearing),
        .dbg_clr_addr (dbg_clr_addr)
    );

    // Reference model: the picture as a plain array plus a count of sweep cycles left.
    logic [DW-1:0] ref_mem [DEPTH];
    int            sweep_left;
    logic [DW-1:0] exp_q [$];
    int            checks = 0;
    int            errors = 0;

    function automatic logic [DW-1:0] model_read(input logic [AW-1:0] a);
        if (int'(a) >= DEPTH) return '0;
        return ref_mem[int'(a)];
    endfunction

    task automatic check(input string tag, input logic [AW-1:0] got, input logic [AW-1:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    // One clock: predict outputs from the pre-edge model, advance the model, then compare.
    task automatic tick();
        logic [DW-1:0] e1;
        logic [DW-1:0] e2;
        logic          e_clr;
        logic [AW-1:0] e_ca;
        e1 = model_read(bus.raddr);
        e2 = model_read(bus.raddr2);
        if (rst || sweep_left > 0) begin
            e1 = '0;
            e2 = '0;
        end
        exp_q.push_back(e1);
        exp_q.push_back(e2);
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
            sweep_left = DEPTH;
        end else if (sweep_left > 0) begin
            sweep_left--;
        end else if (bus.we && int'(bus.waddr) < DEPTH) begin
            ref_mem[int'(bus.waddr)] = bus.din;
        end
        e_clr = (sweep_left > 0);
        e_ca  = AW'(DEPTH - sweep_left);
        @(posedge clk);
        #1;
        check("dout", AW'(bus.dout), AW'(exp_q.pop_front()));
        check("dout2", AW'(bus.dout2), AW'(exp_q.pop_front()));
        check("clearing", AW'(dbg_clearing), AW'(e_clr));
        if (e_clr) check("clr_addr", dbg_clr_addr, e_ca);
    endtask

    task automatic drive(input logic we, input int waddr, input int din, input int ra, input int ra2);
        bus.we     = we;
        bus.waddr  = AW'(waddr);
        bus.din    = DW'(din);
        bus.raddr  = AW'(ra);
        bus.raddr2 = AW'(ra2);
        tick();
    endtask

    task automatic run(input int n);
        repeat (n) tick();
    endtask

    int addr_list [16];

    initial begin
        sweep_left = 0;
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
        bus.we = 1'b0; bus.waddr = '0; bus.din = '0; bus.raddr = '0; bus.raddr2 = '0;

        // Reset held two cycles, then the full sweep.
        rst = 1'b1;
        run(2);
        rst = 1'b0;
        run(DEPTH);
        drive(1'b0, 0, 0, 0, DEPTH - 1);

        // Write then read back with one-cycle latency.
        drive(1'b1, 5, 3'b101, 0, 0);
        drive(1'b0, 0, 0, 5, 5);
        drive(1'b0, 0, 0, 0, 0);

        // Read-first collision: old 2 on the colliding read, 6 on the next one.
        drive(1'b1, 7, 2, 0, 0);
        drive(1'b1, 7, 6, 7, 7);
        drive(1'b0, 0, 0, 7, 0);
        drive(1'b0, 0, 0, 0, 0);

        // Both ports at once, including the last pixel.
        drive(1'b1, 10, 1, 0, 0);
        drive(1'b1, DEPTH - 1, 4, 0, 0);
        drive(1'b0, 0, 0, 10, DEPTH - 1);
        drive(1'b0, 0, 0, 0, 0);

        // Out-of-range write is dropped and out-of-range reads return 0.
        drive(1'b1, DEPTH, 7, 0, 0);
        drive(1'b1, 65535, 7, 0, 0);
        drive(1'b0, 0, 0, DEPTH, 0);
        drive(1'b0, 0, 0, DEPTH - 16384, 0);
        drive(1'b0, 0, 0, 0, 65535);
        drive(1'b0, 0, 0, 0, 0);

        // Randomized traffic concentrated on a small window so reads hit written pixels.
        for (int n = 0; n < 600; n++) begin
            int wa, ra, rb;
            wa = ($urandom_range(0, 9) == 0) ? int'($urandom_range(DEPTH - 4, 65535)) : int'($urandom_range(0, 31));
            ra = ($urandom_range(0, 9) == 0) ? int'($urandom_range(DEPTH - 4, 65535)) : int'($urandom_range(0, 31));
            rb = ($urandom_range(0, 7) == 0) ? int'($urandom_range(DEPTH - 4, DEPTH + 4)) : int'($urandom_range(0, 31));
            drive(1'($urandom_range(0, 1)), wa, int'($urandom_range(0, 7)), ra, rb);
        end

        // Fill, reset for one cycle, attempt writes during the sweep, then confirm all zero.
        for (int i = 0; i < 16; i++) begin
            addr_list[i] = int'($urandom_range(0, DEPTH - 1));
            drive(1'b1, addr_list[i], int'($urandom_range(1, 7)), addr_list[i], 0);
        end
        drive(1'b0, 0, 0, addr_list[0], addr_list[1]);
        rst = 1'b1;
        drive(1'b0, 0, 0, addr_list[0], addr_list[1]);
        rst = 1'b0;
        for (int i = 0; i < 16; i++) drive(1'b1, addr_list[i], 7, addr_list[i], DEPTH - 1);
        run(DEPTH - 16);
        for (int i = 0; i < 16; i += 2) drive(1'b0, 0, 0, addr_list[i], addr_list[i + 1]);
        drive(1'b1, 123, 5, 0, 0);
        drive(1'b0, 0, 0, 123, 123);
        drive(1'b0, 0, 0, 0, 0);

        // Reset reasserted at clr_addr 5000 restarts the sweep from zero.
        rst = 1'b1;
        run(1);
        rst = 1'b0;
        run(5000);
        check("clr_addr_5000", dbg_clr_addr, AW'(5000));
        rst = 1'b1;
        run(1);
        rst = 1'b0;
        drive(1'b1, 9000, 3, 9000, 0);
        run(DEPTH - 1);
        drive(1'b0, 0, 0, 9000, 123);
        drive(1'b1, 9000, 3, 0, 0);
        drive(1'b0, 0, 0, 9000, 0);
        drive(1'b0, 0, 0, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
